mem_wb_stage: RTL and testbench

// - MEM/WB end of the ARC MIPS pipeline. Takes the EX/MEM bundle, runs the data-memory access

---
 rtl/arc_pkg.sv | 12 +
 rtl/mem_wb_stage_if.sv | 23 ++
 rtl/mem_wb_fsm.sv | 83 ++++++++
 rtl/mem_wb_stage.sv | 123 ++++++++++++
 tb/tb_mem_wb_stage.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arc_pkg.sv
// Shared types and constants for the MEM/WB end of the ARC MIPS pipeline.
package arc_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } memwb_state_t;

  // Architectural zero register; writes to it are suppressed.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the memory.
interface mem_wb_stage_if #(
  parameter int unsigned DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_wb_fsm.sv
// Memory-access sequencer: idle/wait state, timeout counter, stall and sticky error.
module mem_wb_fsm
  import arc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_memop,
  input  logic i_mem_ack,
  output logic o_mem_req,
  output logic o_stall_c,
  output logic o_start_c,
  output logic o_done_c,
  output logic o_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  memwb_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             expire_c;

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state; stall is held while waiting unless ack or timeout releases it this cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    o_stall_c = 1'b0;
    o_start_c = 1'b0;
    o_done_c  = 1'b0;
    expire_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_memop) begin
          o_stall_c = 1'b1;
          o_start_c = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        expire_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
        if (i_mem_ack) begin
          o_done_c = 1'b1;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else if (expire_c) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          o_stall_c = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (i_rst) begin
      o_stall_c = 1'b0;
      o_start_c = 1'b0;
      o_done_c  = 1'b0;
    end
  end

  assign o_mem_req = (state_q == S_WAIT);
  assign o_err     = err_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline end: data-memory access with wait states and register-bank write port.
module mem_wb_stage
  import arc_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_con_memread,
  input  logic              i_con_memwrite,
  input  logic              i_con_memtoreg,
  input  logic              i_con_regwrite,
  input  logic [DATA_W-1:0] i_data_alu,
  input  logic [DATA_W-1:0] i_data_rt,
  input  logic [REG_AW-1:0] i_addr_dst,
  output logic              o_stall,
  mem_wb_stage_if.master    mem,
  output logic              o_con_RegWr,
  output logic [REG_AW-1:0] o_addr_WrReg,
  output logic [DATA_W-1:0] o_data_WrData,
  output logic              o_err
);

  logic memop_c, stall_c, start_c, done_c, mem_req;

  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic              regwrite_q, regwrite_d;
  logic              memtoreg_q, memtoreg_d;
  logic              regwr_q, regwr_d;
  logic [REG_AW-1:0] wrreg_q, wrreg_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;

  assign memop_c = i_valid & (i_con_memread | i_con_memwrite);

  mem_wb_fsm #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_fsm (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_memop  (memop_c),
    .i_mem_ack(mem.mem_ack),
    .o_mem_req(mem_req),
    .o_stall_c(stall_c),
    .o_start_c(start_c),
    .o_done_c (done_c),
    .o_err    (o_err)
  );

  // Latch the memop bundle on entry; build the MEM/WB write from ALU or completed access.
  always_comb begin
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dst_d      = dst_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    regwr_d    = 1'b0;
    wrreg_d    = wrreg_q;
    wrdata_d   = wrdata_q;
    if (start_c) begin
      we_d       = i_con_memwrite;
      addr_d     = i_data_alu;
      wdata_d    = i_data_rt;
      dst_d      = i_addr_dst;
      regwrite_d = i_con_regwrite;
      memtoreg_d = i_con_memtoreg;
    end
    if (done_c) begin
      regwr_d = regwrite_q & (dst_q != REG_AW'(REG_ZERO));
      if (regwr_d) begin
        wrreg_d  = dst_q;
        wrdata_d = memtoreg_q ? mem.mem_rdata : addr_q;
      end
    end else if (!mem_req && !memop_c) begin
      regwr_d = i_valid & i_con_regwrite & (i_addr_dst != REG_AW'(REG_ZERO));
      if (regwr_d) begin
        wrreg_d  = i_addr_dst;
        wrdata_d = i_data_alu;
      end
    end
  end

  // Access latches and MEM/WB register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dst_q      <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      regwr_q    <= 1'b0;
      wrreg_q    <= '0;
      wrdata_q   <= '0;
    end else begin
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dst_q      <= dst_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      regwr_q    <= regwr_d;
      wrreg_q    <= wrreg_d;
      wrdata_q   <= wrdata_d;
    end
  end

  assign o_stall       = stall_c;
  assign mem.mem_req   = mem_req;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign o_con_RegWr   = regwr_q;
  assign o_addr_WrReg  = wrreg_q;
  assign o_data_WrData = wrdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a write-back scoreboard.
module tb_mem_wb_stage;

  typedef struct packed {
    logic [4:0]  dst;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, memread, memwrite, memtoreg, regwrite;
  logic [31:0] alu, rt;
  logic [4:0]  dst;
  logic        stall, regwr, err;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;

  int total = 0;
  int bad   = 0;
  wb_t exp_q[$];

  mem_wb_stage_if #(.DATA_W(32)) mem_if ();

  mem_wb_stage #(
    .DATA_W     (32),
    .REG_AW     (5),
    .TIMEOUT_CYC(4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .i_con_memread (memread),
    .i_con_memwrite(memwrite),
    .i_con_memtoreg(memtoreg),
    .i_con_regwrite(regwrite),
    .i_data_alu    (alu),
    .i_data_rt     (rt),
    .i_addr_dst    (dst),
    .o_stall       (stall),
    .mem           (mem_if),
    .o_con_RegWr   (regwr),
    .o_addr_WrReg  (wrreg),
    .o_data_WrData (wrdata),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic m2r,
                       input logic rw, input logic [4:0] d, input logic [31:0] a,
                       input logic [31:0] r);
    valid = v; memread = rd; memwrite = wr; memtoreg = m2r;
    regwrite = rw; dst = d; alu = a; rt = r;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  // Scoreboard: every register-bank write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && regwr === 1'b1) begin
      total++;
      assert (exp_q.size() > 0)
      else begin
        bad++;
        $error("FAIL wb_unexpected observed=write r%0d=%h expected=no write", wrreg, wrdata);
      end
      if (exp_q.size() > 0) begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_dst", 32'(wrreg), 32'(e.dst));
        chk("wb_data", wrdata, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 32'h0;
    tick(); tick();
    chk("rst_regwr", 32'(regwr), 32'd0);
    chk("rst_wrreg", 32'(wrreg), 32'd0);
    chk("rst_wrdata", wrdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(mem_if.mem_req), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    // ALU op writes r5 with latency 1
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);
    exp_q.push_back('{dst: 5'd5, data: 32'h1234});
    #1 chk("alu_stall", 32'(stall), 32'd0);
    tick();
    idle();
    chk("alu_regwr", 32'(regwr), 32'd1);
    chk("alu_wrreg", 32'(wrreg), 32'd5);
    chk("alu_wrdata", wrdata, 32'h1234);
    tick();

    // regwrite to $0 is suppressed and WB address/data hold
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h99, 32'h0);
    tick();
    idle();
    chk("r0_regwr", 32'(regwr), 32'd0);
    chk("r0_wrreg_hold", 32'(wrreg), 32'd5);
    chk("r0_wrdata_hold", wrdata, 32'h1234);

    // Load with ack on the third wait cycle
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h100, 32'h0);
    exp_q.push_back('{dst: 5'd8, data: 32'hDEADBEEF});
    #1 chk("ld_stall_idle", 32'(stall), 32'd1);
    chk("ld_req_idle", 32'(mem_if.mem_req), 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("ld_req", 32'(mem_if.mem_req), 32'd1);
      chk("ld_we", 32'(mem_if.mem_we), 32'd0);
      chk("ld_addr", mem_if.mem_addr, 32'h100);
      chk("ld_stall", 32'(stall), 32'd1);
      chk("ld_regwr_bubble", 32'(regwr), 32'd0);
      tick();
    end
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hDEADBEEF;
    #1 chk("ld_req_ack", 32'(mem_if.mem_req), 32'd1);
    chk("ld_addr_ack", mem_if.mem_addr, 32'h100);
    chk("ld_stall_ack", 32'(stall), 32'd0);
    tick();
    mem_if.mem_ack = 1'b0;
    idle();
    chk("ld_req_done", 32'(mem_if.mem_req), 32'd0);
    chk("ld_regwr", 32'(regwr), 32'd1);
    chk("ld_wrreg", 32'(wrreg), 32'd8);
    chk("ld_wrdata", wrdata, 32'hDEADBEEF);
    tick();

    // Store with ack on the first wait cycle; both flags set means store
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h40, 32'hA5A5);
    tick();
    chk("st_req", 32'(mem_if.mem_req), 32'd1);
    chk("st_we", 32'(mem_if.mem_we), 32'd1);
    chk("st_addr", mem_if.mem_addr, 32'h40);
    chk("st_wdata", mem_if.mem_wdata, 32'hA5A5);
    mem_if.mem_ack = 1'b1;
    #1 chk("st_stall_ack", 32'(stall), 32'd0);
    tick();
    mem_if.mem_ack = 1'b0;
    idle();
    chk("st_regwr", 32'(regwr), 32'd0);
    chk("st_req_done", 32'(mem_if.mem_req), 32'd0);
    tick();

    // Back-to-back loads: second re-stalls immediately after the first completes
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h200, 32'h0);
    exp_q.push_back('{dst: 5'd9, data: 32'h11111111});
    exp_q.push_back('{dst: 5'd10, data: 32'h22222222});
    tick();
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'h11111111;
    tick();
    mem_if.mem_ack = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h204, 32'h0);
    #1 chk("b2b_stall", 32'(stall), 32'd1);
    chk("b2b_first_data", wrdata, 32'h11111111);
    tick();
    chk("b2b_addr", mem_if.mem_addr, 32'h204);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'h22222222;
    tick();
    mem_if.mem_ack = 1'b0;
    idle();
    chk("b2b_second_data", wrdata, 32'h22222222);
    tick();

    // Ack while no request is outstanding has no effect
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hBAD0BAD0;
    tick();
    chk("stray_ack_regwr", 32'(regwr), 32'd0);
    chk("stray_ack_req", 32'(mem_if.mem_req), 32'd0);
    chk("stray_ack_stall", 32'(stall), 32'd0);
    mem_if.mem_ack = 1'b0;
    tick();

    // Timeout: four wait cycles without ack drop the load and set err
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h300, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("to_req", 32'(mem_if.mem_req), 32'd1);
      chk("to_stall", 32'(stall), 32'd1);
      tick();
    end
    chk("to_req_last", 32'(mem_if.mem_req), 32'd1);
    chk("to_stall_release", 32'(stall), 32'd0);
    chk("to_err_pending", 32'(err), 32'd0);
    tick();
    idle();
    chk("to_err", 32'(err), 32'd1);
    chk("to_req_drop", 32'(mem_if.mem_req), 32'd0);
    chk("to_regwr", 32'(regwr), 32'd0);
    tick(); tick();
    chk("to_err_sticky", 32'(err), 32'd1);

    // Pipeline keeps working after a timeout; err stays set
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h77, 32'h0);
    exp_q.push_back('{dst: 5'd3, data: 32'h77});
    tick();
    idle();
    chk("post_to_wrdata", wrdata, 32'h77);
    chk("post_to_err", 32'(err), 32'd1);
    tick();

    // Reset during a wait aborts the access; a late ack is ignored
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd14, 32'h400, 32'h0);
    tick();
    chk("rw_req_before", 32'(mem_if.mem_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("rw_req", 32'(mem_if.mem_req), 32'd0);
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_regwr", 32'(regwr), 32'd0);
    chk("rw_err", 32'(err), 32'd0);
    idle();
    rst = 1'b0;
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 32'hCAFEF00D;
    tick();
    chk("rw_late_ack_regwr", 32'(regwr), 32'd0);
    chk("rw_late_ack_req", 32'(mem_if.mem_req), 32'd0);
    mem_if.mem_ack = 1'b0;
    tick(); tick();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
